// File: rtl/instr_stream_decoder_pkg.sv
// TPU ISA definitions shared by the instruction stream decoder and its record FIFO.
// Opcode map, instruction classes and the decoded record layout.
package tpu_isa_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'h3F;

    // Records carry up to eight operand bytes; narrower builds leave the top bytes zero.
    localparam int MAX_OPERAND_BYTES = 8;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_MATRIX  = 3'd2,
        CLS_ACT     = 3'd3,
        CLS_POOL    = 3'd4,
        CLS_NORM    = 3'd5,
        CLS_CTRL    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_t;

    typedef struct packed {
        logic [7:0]                       opcode;
        instr_class_t                     cls;
        logic [8*MAX_OPERAND_BYTES-1:0]   operand;
        logic                             illegal;
    } decoded_instr_t;

    function automatic instr_class_t classify(input logic [7:0] op);
        instr_class_t c;
        if (op == OP_NOP)                         c = CLS_NOP;
        else if (op >= 8'h01 && op <= 8'h05)      c = CLS_MEM;
        else if (op >= 8'h10 && op <= 8'h12)      c = CLS_MATRIX;
        else if (op >= 8'h18 && op <= 8'h1B)      c = CLS_ACT;
        else if (op >= 8'h20 && op <= 8'h21)      c = CLS_POOL;
        else if (op >= 8'h22 && op <= 8'h23)      c = CLS_NORM;
        else if (op == 8'h30 || op == 8'h31 || op == OP_HALT) c = CLS_CTRL;
        else                                      c = CLS_ILLEGAL;
        return c;
    endfunction

    function automatic logic needs_operands(input logic [7:0] op);
        return (op == 8'h03) || (op == 8'h04) || (op == 8'h05) || (op == 8'h31);
    endfunction

endpackage

// File: rtl/instr_stream_decoder_fifo.sv
// First-word-fall-through FIFO of decoded instruction records with occupancy count.
// Head is read straight from storage, so a push is visible the following cycle.
module decoded_instr_fifo
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  decoded_instr_t            push_data,
    input  logic                      pop,
    output decoded_instr_t            head,
    output logic                      valid,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    decoded_instr_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/instr_stream_decoder.sv
// Assembles opcode + operand bytes from the host stream into decoded records for the TPU controller.
// Optional mid-operand idle timeout is built when DEC_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// COLLECT | gathering OPERAND_BYTES operand bytes for the latched opcode
module instr_stream_decoder
    import tpu_isa_pkg::*;
#(
    parameter int BYTE_W         = 8,
    parameter int OPERAND_BYTES  = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W-1:0]             in_byte,
    input  logic                          resume,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BYTE_W-1:0]             out_opcode,
    output logic [2:0]                    out_class,
    output logic [8*OPERAND_BYTES-1:0]    out_operand,
    output logic                          out_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          halted,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int OPW   = 8*OPERAND_BYTES;
    localparam int CNT_W = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OPERAND_BYTES - 1);
    localparam logic [FCW-1:0]   FIFO_FULL = FCW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         byte8;
    logic [7:0]         opcode_q;
    logic [OPW-1:0]     operand_q;
    logic [OPW-1:0]     operand_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               push;
    logic               start_collect;
    logic               halt_set;
    logic               timeout_hit;
    decoded_instr_t     push_rec;
    decoded_instr_t     head_rec;

    assign byte8    = 8'(in_byte);
    assign in_ready = !halted && (fifo_count < FIFO_FULL);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == S_COLLECT);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && needs_operands(byte8)) state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (accept && cnt_q == LAST_CNT) state_next = S_IDLE;
                else if (timeout_hit)            state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        push          = 1'b0;
        start_collect = 1'b0;
        halt_set      = 1'b0;
        push_rec      = '0;
        operand_next  = operand_q;
        for (int i = 0; i < OPERAND_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) operand_next[8*i +: 8] = byte8;
        end
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (needs_operands(byte8)) begin
                        start_collect = 1'b1;
                    end else if (byte8 != OP_NOP) begin
                        push             = 1'b1;
                        push_rec.opcode  = byte8;
                        push_rec.cls     = classify(byte8);
                        push_rec.illegal = (classify(byte8) == CLS_ILLEGAL);
                        halt_set         = (byte8 == OP_HALT);
                    end
                end
            end
            S_COLLECT: begin
                if (accept && cnt_q == LAST_CNT) begin
                    push             = 1'b1;
                    push_rec.opcode  = opcode_q;
                    push_rec.cls     = classify(opcode_q);
                    push_rec.operand = (8*MAX_OPERAND_BYTES)'(operand_next);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q  <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            halted    <= 1'b0;
        end else begin
            if (start_collect) begin
                opcode_q  <= byte8;
                operand_q <= '0;
                cnt_q     <= '0;
            end else if (state == S_COLLECT && accept) begin
                operand_q <= operand_next;
                cnt_q     <= cnt_q + 1'b1;
            end
            if (halt_set)            halted <= 1'b1;
            else if (halted && resume) halted <= 1'b0;
        end
    end

`ifdef DEC_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt_q;
    logic              err_timeout_q;

    // Down-counter reloads on every accepted byte; a full-FIFO stall keeps in_valid high so it never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q    <= IDLE_LOAD;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= timeout_hit;
            if (state != S_COLLECT || accept)     idle_cnt_q <= IDLE_LOAD;
            else if (!in_valid && idle_cnt_q != '0) idle_cnt_q <= idle_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = (state == S_COLLECT) && !in_valid && (idle_cnt_q == '0);
    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    decoded_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_rec),
        .pop       (out_valid && out_ready),
        .head      (head_rec),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_opcode  = BYTE_W'(head_rec.opcode);
    assign out_class   = head_rec.cls;
    assign out_operand = head_rec.operand[OPW-1:0];
    assign out_illegal = head_rec.illegal;

    generate
        if (OPW < 8*MAX_OPERAND_BYTES) begin : g_hi
            logic unused_operand_hi;
            assign unused_operand_hi = ^head_rec.operand[8*MAX_OPERAND_BYTES-1:OPW];
        end
    endgenerate

endmodule

// File: tb/tb_instr_stream_decoder.sv
// Scoreboard bench for instr_stream_decoder; timeout scenario follows DEC_TIMEOUT_EN.
module tb_instr_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        resume;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [2:0]  out_class;
    logic [31:0] out_operand;
    logic        out_illegal;
    logic [2:0]  fifo_count;
    logic        halted;
    logic        busy;
    logic        err_timeout;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  cls;
        logic [31:0] operand;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_rx   = 0;

    instr_stream_decoder #(
        .BYTE_W(8), .OPERAND_BYTES(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .resume(resume), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_class(out_class), .out_operand(out_operand), .out_illegal(out_illegal),
        .fifo_count(fifo_count), .halted(halted), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_class(input logic [7:0] b);
        if (b == 8'h00)                  return 3'd0;
        if (b >= 8'h01 && b <= 8'h05)    return 3'd1;
        if (b >= 8'h10 && b <= 8'h12)    return 3'd2;
        if (b >= 8'h18 && b <= 8'h1B)    return 3'd3;
        if (b == 8'h20 || b == 8'h21)    return 3'd4;
        if (b == 8'h22 || b == 8'h23)    return 3'd5;
        if (b == 8'h30 || b == 8'h31 || b == 8'h3F) return 3'd6;
        return 3'd7;
    endfunction

    function automatic bit model_needs(input logic [7:0] b);
        return (b == 8'h03) || (b == 8'h04) || (b == 8'h05) || (b == 8'h31);
    endfunction

    // Scoreboard: every popped record must match the oldest expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_rx++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record got op=%h cls=%0d opnd=%h ill=%b",
                         out_opcode, out_class, out_operand, out_illegal);
            end else begin
                e = exp_q.pop_front();
                if (out_opcode !== e.op || out_class !== e.cls ||
                    out_operand !== e.operand || out_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL record got op=%h cls=%0d opnd=%h ill=%b want op=%h cls=%0d opnd=%h ill=%b",
                             out_opcode, out_class, out_operand, out_illegal,
                             e.op, e.cls, e.operand, e.ill);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] op, input logic [31:0] operand);
        exp_t x;
        x.op      = op;
        x.cls     = model_class(op);
        x.operand = model_needs(op) ? operand : 32'h0;
        x.ill     = (model_class(op) == 3'd7);
        exp_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_wait byte=%h got not_accepted want accepted", b);
        end
    endtask

    task automatic send_instr(input logic [7:0] op, input logic [31:0] operand);
        bit ok;
        send_byte(op, ok);
        if (model_needs(op)) begin
            for (int i = 0; i < 4; i++) send_byte(operand[8*i +: 8], ok);
        end
        if (op != 8'h00) push_exp(op, operand);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain got pending=%0d out_valid=%b want 0 0", exp_q.size(), out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; resume = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_fifo got valid=%b count=%0d want 0 0", out_valid, fifo_count);
        end
        checks++;
        if (halted !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_status got halted=%b busy=%b err=%b want 0 0 0", halted, busy, err_timeout);
        end
        checks++;
        if (out_opcode !== 8'h00 || out_operand !== 32'h0 || out_class !== 3'd0 || out_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got op=%h opnd=%h cls=%0d ill=%b want zeros",
                               out_opcode, out_operand, out_class, out_illegal);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_instr(8'h10, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== 8'h10) begin
            errors++; $display("FAIL latency_10 got valid=%b op=%h want 1 10", out_valid, out_opcode);
        end
        send_instr(8'h18, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== 8'h18 || out_class !== 3'd3) begin
            errors++; $display("FAIL latency_18 got valid=%b op=%h cls=%0d want 1 18 3", out_valid, out_opcode, out_class);
        end
        wait_drain();
    endtask

    task automatic test_operands();
        bit ok;
        logic [31:0] opnd = 32'h44332211;
        int bad = 0;
        out_ready = 1'b1;
        send_byte(8'h04, ok);
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
            send_byte(opnd[8*i +: 8], ok);
        end
        push_exp(8'h04, opnd);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_collect got bad_cycles=%0d want 0", bad); end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL operand_done got busy=%b valid=%b want 0 1", busy, out_valid);
        end
        wait_drain();
    endtask

    task automatic test_nop_illegal();
        out_ready = 1'b1;
        send_instr(8'h00, 32'h0);
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL nop_dropped got valid=%b count=%0d busy=%b want 0 0 0", out_valid, fifo_count, busy);
        end
        send_instr(8'h7E, 32'h0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL illegal_no_operands got busy=%b want 0", busy); end
        send_instr(8'h02, 32'h0);
        wait_drain();
    endtask

    task automatic test_full();
        bit ok;
        int bad = 0;
        int rx0;
        out_ready = 1'b0;
        rx0 = n_rx;
        repeat (4) send_instr(8'h20, 32'h0);
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_state got count=%0d in_ready=%b want 4 0", fifo_count, in_ready);
        end
        fork
            begin
                send_byte(8'h21, ok);
                if (ok) push_exp(8'h21, 32'h0);
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (in_ready !== 1'b0 || fifo_count !== 3'd4) bad++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_hold got bad_cycles=%0d want 0", bad); end
        wait_drain();
        checks++;
        if (n_rx - rx0 != 5) begin errors++; $display("FAIL full_count got records=%0d want 5", n_rx - rx0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [6] = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_instr(ops[i], 32'h0);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++; $display("FAIL push_pop_count got %0d want 1", fifo_count);
        end
        wait_drain();
    endtask

    task automatic test_halt();
        int bad = 0;
        out_ready = 1'b1;
        send_instr(8'h3F, 32'h0);
        checks++;
        if (halted !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL halt_enter got halted=%b in_ready=%b want 1 0", halted, in_ready);
        end
        in_valid = 1'b1;
        in_byte  = 8'h10;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || halted !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || exp_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL halt_stall got bad=%0d pending=%0d count=%0d want 0 0 0", bad, exp_q.size(), fifo_count);
        end
        @(posedge clk);
        #1 resume = 1'b1;
        @(posedge clk);
        #1 resume = 1'b0;
        checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL resume got halted=%b in_ready=%b want 0 1", halted, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        push_exp(8'h10, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== 8'h10) begin
            errors++; $display("FAIL resume_accept got valid=%b op=%h want 1 10", out_valid, out_opcode);
        end
        wait_drain();
        resume = 1'b1;
        @(posedge clk);
        #1 resume = 1'b0;
        checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL resume_ignored got halted=%b in_ready=%b want 0 1", halted, in_ready);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int pulses = 0;
        int first  = -1;
        int rx0;
        out_ready = 1'b1;
        rx0 = n_rx;
        send_byte(8'h31, ok);
        send_byte(8'hAA, ok);
`ifdef DEC_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (pulses != 1 || first != 8) begin
            errors++; $display("FAIL timeout_pulse got pulses=%0d at=%0d want 1 at 8", pulses, first);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || n_rx != rx0) begin
            errors++; $display("FAIL timeout_abandon got busy=%b valid=%b records=%0d want 0 0 0", busy, out_valid, n_rx - rx0);
        end
        @(posedge clk);
        #1;
        send_instr(8'h10, 32'h0);
        wait_drain();
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err_timeout !== 1'b0 || busy !== 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || n_rx != rx0) begin
            errors++; $display("FAIL no_timeout got bad=%0d records=%0d want 0 0", pulses, n_rx - rx0);
        end
        @(posedge clk);
        #1;
        send_byte(8'hBB, ok);
        send_byte(8'hCC, ok);
        send_byte(8'hDD, ok);
        push_exp(8'h31, 32'hDDCCBBAA);
        wait_drain();
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        send_instr(8'h20, 32'h0);
        send_instr(8'h22, 32'h0);
        send_byte(8'h05, ok);
        send_byte(8'h99, ok);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        exp_q.delete();
        #1 rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid got busy=%b count=%0d valid=%b want 0 0 0", busy, fifo_count, out_valid);
        end
        out_ready = 1'b1;
        send_instr(8'h05, 32'h12345678);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_operands();
        test_nop_illegal();
        test_full();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover got pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
